instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Program-side producer of the 16-bit instruction bus consumed by the TPU control decoder.
- Holds a small host-loaded program memory, a program counter and an issue FSM.
- Issues one instruction per cycle in program order. Emits NOP (16'h0000) whenever nothing must fire, because the decoder re-acts to any opcode it samples.
- Handles two local opcodes that are never forwarded: WAIT (3'b110) and HALT (3'b111).

Parameters:
- DEPTH, 64, program memory depth in 16-bit words.
- AW, 6, address/PC width; must equal clog2(DEPTH).

Ports:
- clk  in  1  clock, all logic rising-edge.
- reset  in  1  synchronous, active-low (0 = reset).
- prog_we  in  1  program memory write enable.
- prog_addr  in  AW  program write address.
- prog_data  in  16  program write data.
- start  in  1  begin execution; honoured only in IDLE or DONE.
- start_pc  in  AW  first PC on start.
- stall  in  1  downstream not ready; freeze fetch.
- instruction  out  16  registered instruction to decoder; [15:13] opcode, [12:0] immediate.
- instr_valid  out  1  high when instruction carries opcode 001..101.
- pc  out  AW  current PC register.
- busy  out  1  state is RUN or WAIT.
- done  out  1  state is DONE (HALT executed).

Behaviour:
- Reset (sampled reset==0 at edge):
  - state=IDLE, pc=0, wait_cnt=0, instruction=0, instr_valid=0.
  - busy and done are 0.
  - Memory contents are not cleared.
  - Reset mid-RUN or mid-WAIT takes effect at that edge.
- Memory:
  - Synchronous write when prog_we=1, legal in any state.
  - Fetch read of the same address in the same cycle returns the old word (read-before-write).
- States: IDLE, RUN, WAIT, DONE. busy and done decode combinationally from state.
- IDLE: output NOP, valid 0. start=1 -> pc<=start_pc, go to RUN.
- RUN, stall=1: instruction<=0, valid<=0, pc held, state held. No instruction is skipped or repeated.
- RUN, stall=0, fetch w=mem[pc], decode w[15:13]:
  - 001..101: instruction<=w, instr_valid<=1, pc<=pc+1.
  - 000: instruction<=0, valid<=0, pc<=pc+1.
  - 110 WAIT: instruction<=0, valid<=0, pc<=pc+1, wait_cnt<=w[12:0]. Go to WAIT if w[12:0]!=0, else stay in RUN.
  - 111 HALT: instruction<=0, valid<=0, pc held at HALT address, go to DONE.
- WAIT:
  - Each cycle: instruction<=0, wait_cnt<=wait_cnt-1.
  - stall is ignored; the count always runs.
  - When wait_cnt==1, go to RUN.
  - Net effect: WAIT N yields exactly N+1 NOP output cycles between the preceding and following issued instructions.
- DONE: output NOP, done=1. start=1 -> pc<=start_pc, go to RUN (restart).
- start while busy is ignored.
- Latency: start at edge k -> first fetched instruction on the output after edge k+1. Fetch-to-output latency is 1 cycle.
- PC arithmetic: AW-bit, wraps DEPTH-1 -> 0 with no flag.
- instruction and instr_valid are registers; no combinational path from any input to any output except busy/done from state.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-run -> instruction=0000, instr_valid=0, pc=0, busy=0, done=0. Previously written memory is still readable after a restart.
- Linear program: mem[0..5]=2005,4000,6000,8000,A000,E000; start, start_pc=0 -> outputs 2005,4000,6000,8000,A000 on 5 consecutive cycles with valid=1. Then 0000, done=1, pc=5, busy=0.
- WAIT: mem[0..3]=4000,C003,8000,E000 -> 4000, then exactly 4 cycles of 0000 (valid=0), then 8000, then halt.
- Stall: run the linear program with stall=1 for 3 cycles after 4000 appears -> 3 extra 0000 cycles, pc frozen, then 6000. Sequence is otherwise identical, no repeats or skips.
- Wrap: start_pc=63, mem[63]=6000, mem[0]=E000 -> 6000 then halt; done=1, pc=0.
- Start/write corner cases:
  - start pulsed during RUN -> ignored, pc unaffected.
  - start in DONE with start_pc=2 -> resumes at mem[2].
  - prog_we to the current fetch address in the same cycle -> the old word is issued.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: issues program-memory words to the control decoder, one per cycle.
// WAIT and HALT are consumed locally; anything not forwarded goes out as NOP.
module instr_sequencer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          start,
  input  logic [AW-1:0] start_pc,
  input  logic          stall,
  output logic [15:0]   instruction,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] pc_n;
  logic [12:0] wait_cnt, cnt_n;
  logic [15:0] instr_n, word;
  logic [2:0] op;
  logic valid_n;
  // Combinational read of the registered PC gives read-before-write on a same-cycle store.
  assign word = mem[pc];
  assign op = word[15:13];
  assign busy = (state == RUN) || (state == WAIT);
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (prog_we) mem[prog_addr] <= prog_data;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pc <= '0;
      wait_cnt <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      wait_cnt <= cnt_n;
      instruction <= instr_n;
      instr_valid <= valid_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n = pc;
    cnt_n = wait_cnt;
    instr_n = '0;
    valid_n = 1'b0;
    if (state == IDLE || state == DONE) begin
      if (start) begin
        pc_n = start_pc;
        state_n = RUN;
      end
    end else if (state == WAIT) begin
      cnt_n = wait_cnt - 13'd1;
      state_n = (wait_cnt == 13'd1) ? RUN : WAIT;
    end else if (!stall) begin
      if (op == 3'b111) begin
        state_n = DONE;
      end else begin
        pc_n = pc + AW'(1);
        valid_n = (op != 3'b000) && (op != 3'b110);
        instr_n = valid_n ? word : 16'h0000;
        if (op == 3'b110) begin
          cnt_n = word[12:0];
          state_n = (word[12:0] != 13'd0) ? WAIT : RUN;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: vector table plus hand sequences, expectations queued and popped per cycle.
module tb_instr_sequencer;
  logic clk = 0, reset = 0, prog_we = 0, start = 0, stall = 0;
  logic [5:0] prog_addr = 0, start_pc = 0, pc;
  logic [15:0] prog_data = 0, instruction;
  logic instr_valid, busy, done;
  int n_cmp = 0, n_bad = 0;

  instr_sequencer #(.DEPTH(64), .AW(6)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .start_pc(start_pc), .stall(stall),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_n, st;
    logic [5:0] spc;
    logic stl, we;
    logic [5:0] wa;
    logic [15:0] wd, ei;
    logic ev;
    logic [5:0] ep;
    logic eb, ed;
  } vec_t;

  typedef struct {
    logic [15:0] i;
    logic v;
    logic [5:0] p;
    logic b, d;
  } exp_t;

  exp_t q[$];
  vec_t tbl[23];

  function automatic vec_t mkv(logic st, logic [5:0] spc, logic stl, logic [15:0] ei,
                               logic ev, logic [5:0] ep, logic eb, logic ed);
    vec_t r;
    r.rst_n = 1; r.st = st; r.spc = spc; r.stl = stl; r.we = 0; r.wa = 0; r.wd = 0;
    r.ei = ei; r.ev = ev; r.ep = ep; r.eb = eb; r.ed = ed;
    return r;
  endfunction

  task automatic cmp(string n, logic [15:0] got, logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  task automatic step(string tag, vec_t x);
    exp_t e;
    reset = x.rst_n; start = x.st; start_pc = x.spc; stall = x.stl;
    prog_we = x.we; prog_addr = x.wa; prog_data = x.wd;
    e.i = x.ei; e.v = x.ev; e.p = x.ep; e.b = x.eb; e.d = x.ed;
    q.push_back(e);
    @(posedge clk); #1;
    e = q.pop_front();
    cmp({tag, " instruction"}, instruction, e.i);
    cmp({tag, " valid"}, 16'(instr_valid), 16'(e.v));
    cmp({tag, " pc"}, 16'(pc), 16'(e.p));
    cmp({tag, " busy"}, 16'(busy), 16'(e.b));
    cmp({tag, " done"}, 16'(done), 16'(e.d));
    start = 0; stall = 0; prog_we = 0;
  endtask

  task automatic load(logic [5:0] a, logic [15:0] d);
    reset = 1; start = 0; stall = 0;
    prog_we = 1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 0;
  endtask

  initial begin
    vec_t r;
    logic [15:0] lin[6];
    lin[0] = 16'h2005; lin[1] = 16'h4000; lin[2] = 16'h6000;
    lin[3] = 16'h8000; lin[4] = 16'hA000; lin[5] = 16'hE000;
    // Linear run, then stalled rerun with an ignored mid-run start, then restart at 2.
    tbl[0]  = mkv(1, 0, 0, 16'h0000, 0, 0, 1, 0);
    tbl[1]  = mkv(0, 0, 0, 16'h2005, 1, 1, 1, 0);
    tbl[2]  = mkv(0, 0, 0, 16'h4000, 1, 2, 1, 0);
    tbl[3]  = mkv(0, 0, 0, 16'h6000, 1, 3, 1, 0);
    tbl[4]  = mkv(0, 0, 0, 16'h8000, 1, 4, 1, 0);
    tbl[5]  = mkv(0, 0, 0, 16'hA000, 1, 5, 1, 0);
    tbl[6]  = mkv(0, 0, 0, 16'h0000, 0, 5, 0, 1);
    tbl[7]  = mkv(0, 0, 0, 16'h0000, 0, 5, 0, 1);
    tbl[8]  = mkv(1, 0, 0, 16'h0000, 0, 0, 1, 0);
    tbl[9]  = mkv(0, 0, 0, 16'h2005, 1, 1, 1, 0);
    tbl[10] = mkv(0, 0, 0, 16'h4000, 1, 2, 1, 0);
    tbl[11] = mkv(0, 0, 1, 16'h0000, 0, 2, 1, 0);
    tbl[12] = mkv(0, 0, 1, 16'h0000, 0, 2, 1, 0);
    tbl[13] = mkv(0, 0, 1, 16'h0000, 0, 2, 1, 0);
    tbl[14] = mkv(0, 0, 0, 16'h6000, 1, 3, 1, 0);
    tbl[15] = mkv(0, 0, 0, 16'h8000, 1, 4, 1, 0);
    tbl[16] = mkv(1, 2, 0, 16'hA000, 1, 5, 1, 0);
    tbl[17] = mkv(0, 0, 0, 16'h0000, 0, 5, 0, 1);
    tbl[18] = mkv(1, 2, 0, 16'h0000, 0, 2, 1, 0);
    tbl[19] = mkv(0, 0, 0, 16'h6000, 1, 3, 1, 0);
    tbl[20] = mkv(0, 0, 0, 16'h8000, 1, 4, 1, 0);
    tbl[21] = mkv(0, 0, 0, 16'hA000, 1, 5, 1, 0);
    tbl[22] = mkv(0, 0, 0, 16'h0000, 0, 5, 0, 1);

    r = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    r.rst_n = 0;
    step("reset0", r);
    step("reset1", r);
    for (int i = 0; i < 6; i++) load(6'(i), lin[i]);
    for (int i = 0; i < 23; i++) step($sformatf("vec%0d", i), tbl[i]);

    load(0, 16'h4000); load(1, 16'hC003); load(2, 16'h8000); load(3, 16'hE000);
    step("wait0", mkv(1, 0, 0, 16'h0000, 0, 0, 1, 0));
    step("wait1", mkv(0, 0, 0, 16'h4000, 1, 1, 1, 0));
    step("wait2", mkv(0, 0, 0, 16'h0000, 0, 2, 1, 0));
    step("wait3", mkv(0, 0, 1, 16'h0000, 0, 2, 1, 0));
    step("wait4", mkv(0, 0, 0, 16'h0000, 0, 2, 1, 0));
    step("wait5", mkv(0, 0, 0, 16'h0000, 0, 2, 1, 0));
    step("wait6", mkv(0, 0, 0, 16'h8000, 1, 3, 1, 0));
    step("wait7", mkv(0, 0, 0, 16'h0000, 0, 3, 0, 1));

    load(63, 16'h6000); load(0, 16'hE000);
    step("wrap0", mkv(1, 63, 0, 16'h0000, 0, 63, 1, 0));
    step("wrap1", mkv(0, 0, 0, 16'h6000, 1, 0, 1, 0));
    step("wrap2", mkv(0, 0, 0, 16'h0000, 0, 0, 0, 1));

    step("rbw0", mkv(1, 63, 0, 16'h0000, 0, 63, 1, 0));
    r = mkv(0, 0, 0, 16'h6000, 1, 0, 1, 0);
    r.we = 1; r.wa = 63; r.wd = 16'h2222;
    step("rbw1", r);
    step("rbw2", mkv(0, 0, 0, 16'h0000, 0, 0, 0, 1));
    step("rbw3", mkv(1, 63, 0, 16'h0000, 0, 63, 1, 0));
    step("rbw4", mkv(0, 0, 0, 16'h2222, 1, 0, 1, 0));
    step("rbw5", mkv(0, 0, 0, 16'h0000, 0, 0, 0, 1));

    load(62, 16'hC005);
    step("mrst0", mkv(1, 62, 0, 16'h0000, 0, 62, 1, 0));
    step("mrst1", mkv(0, 0, 0, 16'h0000, 0, 63, 1, 0));
    r = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    r.rst_n = 0;
    step("mrst2", r);
    step("mrst3", r);
    step("mrst4", mkv(1, 63, 0, 16'h0000, 0, 63, 1, 0));
    step("mrst5", mkv(0, 0, 0, 16'h2222, 1, 0, 1, 0));
    step("mrst6", mkv(0, 0, 0, 16'h0000, 0, 0, 0, 1));

    cmp("queue drained", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
